// File: rtl/alu_issue_if.sv
// Handshake bundle between register-file read, the ALU issue stage and the ALU.
// The slave modport is the issue stage; master is the upstream/downstream environment.
interface alu_issue_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_op;
  logic [4:0]      rd;
  logic            rd_we;
  logic            illegal;

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, rd, rd_we, illegal
  );

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, rd, rd_we, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU operands and alu_op,
// then buffers the result behind a registered valid/ready port with a 2-entry skid.
module alu_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      op;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } beat_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  beat_t      dec;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OpcOp: begin
        legal  = (funct7 == 7'h00) ||
                 ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
        dec.a  = bus.rs1_data;
        dec.b  = bus.rs2_data;
        dec.op = {funct7[5], funct3};
      end
      OpcOpImm: begin
        case (funct3)
          3'd1:    legal = (funct7 == 7'h00);
          3'd5:    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: legal = 1'b1;
        endcase
        dec.a  = bus.rs1_data;
        dec.b  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
        // Only shifts carry a meaningful instr[30]; for ADDI etc. it is immediate data.
        dec.op = {(funct3 == 3'd5) & bus.instr[30], funct3};
      end
      OpcLui: begin
        legal = 1'b1;
        dec.b = {bus.instr[31:12], 12'b0};
      end
      OpcAuipc: begin
        legal = 1'b1;
        dec.a = bus.pc;
        dec.b = {bus.instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      dec.rd    = bus.instr[11:7];
      dec.rd_we = (bus.instr[11:7] != 5'd0);
    end else begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  state_e state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;

  assign accept = bus.in_valid & in_ready_q & ~bus.flush;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = dec;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && bus.out_ready) begin
            main_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = StTwo;
          end else if (bus.out_ready) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (bus.out_ready) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Registered ready: open whenever the skid entry will be free next cycle.
  assign in_ready_d = (state_d != StTwo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.alu_a     = main_q.a;
  assign bus.alu_b     = main_q.b;
  assign bus.alu_op    = main_q.op;
  assign bus.rd        = main_q.rd;
  assign bus.rd_we     = main_q.rd_we;
  assign bus.illegal   = main_q.illegal;

endmodule
